ahb_response_buffer: RTL and testbench

- Sits directly downstream of AHB_READ_HANDLER and consumes its register-write stream (RESPONSE, RESPONSE_ADDR, REG_ENABLE, REG_WRITE).
- Stores each read beat in a DEPTH-entry response buffer with a per-entry valid bit.
- Drains valid entries to the host side over a valid/ready stream, lowest index first.
- Flags any unread entry that is overwritten.

---
 rtl/ahb_response_buffer_pkg.sv | 17 +
 rtl/ahb_response_buffer_if.sv | 30 +++
 rtl/ahb_response_buffer_lsb_prio_enc.sv | 23 ++
 rtl/ahb_response_buffer.sv | 117 +++++++++++
 tb/tb_ahb_response_buffer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/ahb_response_buffer_pkg.sv
// rtl/ahb_response_buffer_pkg.sv - shared defaults and FSM encoding for the response buffer
package ahb_response_buffer_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_HOLD  = 1'b1
    } drain_state_t;

    function automatic int depth_of(input int addr_w);
        return 2 ** addr_w;
    endfunction

endpackage

// File: rtl/ahb_response_buffer_if.sv
// rtl/ahb_response_buffer_if.sv - write-side register stream and host-side drain stream
interface ahb_response_buffer_if
    import ahb_response_buffer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              REG_ENABLE;
    logic              REG_WRITE;
    logic [ADDR_W-1:0] RESPONSE_ADDR;
    logic [DATA_W-1:0] RESPONSE;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [DATA_W-1:0] OUT_DATA;
    logic [ADDR_W-1:0] OUT_ADDR;
    logic [ADDR_W:0]   FILL_COUNT;
    logic              OVERWRITE;

    modport master (
        output REG_ENABLE, REG_WRITE, RESPONSE_ADDR, RESPONSE, OUT_READY,
        input  OUT_VALID, OUT_DATA, OUT_ADDR, FILL_COUNT, OVERWRITE
    );

    modport slave (
        input  REG_ENABLE, REG_WRITE, RESPONSE_ADDR, RESPONSE, OUT_READY,
        output OUT_VALID, OUT_DATA, OUT_ADDR, FILL_COUNT, OVERWRITE
    );

endinterface

// File: rtl/ahb_response_buffer_lsb_prio_enc.sv
// rtl/ahb_response_buffer_lsb_prio_enc.sv - lowest-set-bit index of a vector plus any-set flag
module lsb_prio_enc #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic [DEPTH-1:0]  vec,
    output logic [ADDR_W-1:0] idx,
    output logic              any
);

    // Scan high to low so the last hit, i.e. the lowest index, wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ADDR_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_response_buffer.sv
// rtl/ahb_response_buffer.sv - indexed response store drained lowest-index-first to the host
module ahb_response_buffer
    import ahb_response_buffer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    ahb_response_buffer_if.slave  bus
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  valid_nxt;
    drain_state_t      state;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic [ADDR_W:0]   fill_count;
    logic              overwrite;
    logic              dirty;

    logic              wr;
    logic              hit_held;
    logic              pop;
    logic [ADDR_W-1:0] low_idx;
    logic              low_any;

    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + {{ADDR_W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    lsb_prio_enc #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_prio_enc (
        .vec (valid),
        .idx (low_idx),
        .any (low_any)
    );

    assign wr       = bus.REG_ENABLE && bus.REG_WRITE;
    assign hit_held = (state == S_HOLD) && wr && (bus.RESPONSE_ADDR == out_addr);
    assign pop      = (state == S_HOLD) && bus.OUT_READY;

    // A held entry that was rewritten stays valid so its new data drains later.
    always_comb begin
        valid_nxt = valid;
        if (pop && !dirty && !hit_held) begin
            valid_nxt[out_addr] = 1'b0;
        end
        if (wr) begin
            valid_nxt[bus.RESPONSE_ADDR] = 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (wr && !HRESET) begin
            mem[bus.RESPONSE_ADDR] <= bus.RESPONSE;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            valid      <= '0;
            fill_count <= '0;
            state      <= S_EMPTY;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_addr   <= '0;
            overwrite  <= 1'b0;
            dirty      <= 1'b0;
        end else begin
            valid      <= valid_nxt;
            fill_count <= popcount(valid_nxt);
            if (wr && valid[bus.RESPONSE_ADDR] && !hit_held) begin
                overwrite <= 1'b1;
            end
            case (state)
                S_EMPTY: begin
                    if (low_any) begin
                        out_addr  <= low_idx;
                        out_data  <= mem[low_idx];
                        dirty     <= wr && (bus.RESPONSE_ADDR == low_idx);
                        out_valid <= 1'b1;
                        state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (hit_held) begin
                        dirty <= 1'b1;
                    end
                    if (bus.OUT_READY) begin
                        out_valid <= 1'b0;
                        state     <= S_EMPTY;
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

    assign bus.OUT_VALID  = out_valid;
    assign bus.OUT_DATA   = out_data;
    assign bus.OUT_ADDR   = out_addr;
    assign bus.FILL_COUNT = fill_count;
    assign bus.OVERWRITE  = overwrite;

endmodule

// File: tb/tb_ahb_response_buffer.sv
// tb/tb_ahb_response_buffer.sv - directed self-checking bench for ahb_response_buffer
module tb_ahb_response_buffer;
    import ahb_response_buffer_pkg::*;

    logic HCLK = 1'b0;
    logic HRESET;
    int   checks = 0;
    int   errors = 0;

    ahb_response_buffer_if bus ();

    ahb_response_buffer dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic wr_beat(input logic [4:0] a, input logic [31:0] d);
        bus.REG_ENABLE    = 1'b1;
        bus.REG_WRITE     = 1'b1;
        bus.RESPONSE_ADDR = a;
        bus.RESPONSE      = d;
        tick();
        bus.REG_ENABLE    = 1'b0;
        bus.REG_WRITE     = 1'b0;
    endtask

    task automatic apply_reset();
        HRESET = 1'b1;
        tick();
        tick();
        HRESET = 1'b0;
    endtask

    task automatic test_reset();
        bus.REG_ENABLE = 1'b0; bus.REG_WRITE = 1'b0; bus.RESPONSE_ADDR = '0;
        bus.RESPONSE = '0; bus.OUT_READY = 1'b0;
        apply_reset();
        checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b exp 0", bus.OUT_VALID); end
        checks++; if (bus.FILL_COUNT !== 6'd0) begin errors++; $display("FAIL reset_fill: got %0d exp 0", bus.FILL_COUNT); end
        checks++; if (bus.OVERWRITE !== 1'b0) begin errors++; $display("FAIL reset_ovw: got %0b exp 0", bus.OVERWRITE); end
        checks++; if (bus.OUT_DATA !== 32'd0 || bus.OUT_ADDR !== 5'd0) begin errors++; $display("FAIL reset_out: got data %0d addr %0d exp 0 0", bus.OUT_DATA, bus.OUT_ADDR); end
    endtask

    task automatic test_single_beat();
        bus.OUT_READY = 1'b1;
        wr_beat(5'd1, 32'd10);
        checks++; if (bus.OUT_VALID !== 1'b0 || bus.FILL_COUNT !== 6'd1) begin errors++; $display("FAIL single_n: got valid %0b fill %0d exp 0 1", bus.OUT_VALID, bus.FILL_COUNT); end
        tick();
        checks++; if (bus.OUT_VALID !== 1'b1 || bus.OUT_DATA !== 32'd10 || bus.OUT_ADDR !== 5'd1 || bus.FILL_COUNT !== 6'd1) begin errors++; $display("FAIL single_present: got valid %0b data %0d addr %0d fill %0d exp 1 10 1 1", bus.OUT_VALID, bus.OUT_DATA, bus.OUT_ADDR, bus.FILL_COUNT); end
        tick();
        checks++; if (bus.OUT_VALID !== 1'b0 || bus.FILL_COUNT !== 6'd0) begin errors++; $display("FAIL single_pop: got valid %0b fill %0d exp 0 0", bus.OUT_VALID, bus.FILL_COUNT); end
        tick();
        checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL single_idle: got valid %0b exp 0", bus.OUT_VALID); end
        bus.OUT_READY = 1'b0;
    endtask

    task automatic test_ordering();
        logic [4:0]  exp_addr [3];
        logic [31:0] exp_data [3];
        exp_addr = '{5'd1, 5'd3, 5'd7};
        exp_data = '{32'd10, 32'd20, 32'd30};
        bus.OUT_READY = 1'b0;
        wr_beat(5'd0, 32'd99);
        wr_beat(5'd7, 32'd30);
        wr_beat(5'd3, 32'd20);
        wr_beat(5'd1, 32'd10);
        checks++; if (bus.OUT_ADDR !== 5'd0 || bus.OUT_DATA !== 32'd99 || bus.FILL_COUNT !== 6'd4) begin errors++; $display("FAIL order_first: got addr %0d data %0d fill %0d exp 0 99 4", bus.OUT_ADDR, bus.OUT_DATA, bus.FILL_COUNT); end
        bus.OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.OUT_VALID !== 1'b0 || bus.FILL_COUNT !== 6'(3 - i)) begin errors++; $display("FAIL order_pop%0d: got valid %0b fill %0d exp 0 %0d", i, bus.OUT_VALID, bus.FILL_COUNT, 3 - i); end
            tick();
            if (i < 3) begin
                checks++; if (bus.OUT_VALID !== 1'b1 || bus.OUT_ADDR !== exp_addr[i] || bus.OUT_DATA !== exp_data[i]) begin errors++; $display("FAIL order_load%0d: got valid %0b addr %0d data %0d exp 1 %0d %0d", i, bus.OUT_VALID, bus.OUT_ADDR, bus.OUT_DATA, exp_addr[i], exp_data[i]); end
            end else begin
                checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL order_drained: got valid %0b exp 0", bus.OUT_VALID); end
            end
        end
        bus.OUT_READY = 1'b0;
    endtask

    task automatic test_backpressure();
        bus.OUT_READY = 1'b0;
        wr_beat(5'd5, 32'h55);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.OUT_VALID !== 1'b1 || bus.OUT_DATA !== 32'h55 || bus.OUT_ADDR !== 5'd5) begin errors++; $display("FAIL bp_stable%0d: got valid %0b data %0h addr %0d exp 1 55 5", i, bus.OUT_VALID, bus.OUT_DATA, bus.OUT_ADDR); end
        end
        bus.OUT_READY = 1'b1;
        tick();
        checks++; if (bus.OUT_VALID !== 1'b0 || bus.FILL_COUNT !== 6'd0) begin errors++; $display("FAIL bp_pop: got valid %0b fill %0d exp 0 0", bus.OUT_VALID, bus.FILL_COUNT); end
        tick();
        checks++; if (bus.OUT_VALID !== 1'b0 || bus.FILL_COUNT !== 6'd0) begin errors++; $display("FAIL bp_single: got valid %0b fill %0d exp 0 0", bus.OUT_VALID, bus.FILL_COUNT); end
        bus.OUT_READY = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.OUT_READY = 1'b0;
        wr_beat(5'd0, 32'd5);
        tick();
        checks++; if (bus.OUT_VALID !== 1'b1 || bus.OUT_ADDR !== 5'd0) begin errors++; $display("FAIL b2b_hold: got valid %0b addr %0d exp 1 0", bus.OUT_VALID, bus.OUT_ADDR); end
        bus.OUT_READY = 1'b1;
        wr_beat(5'd9, 32'd77);
        bus.OUT_READY = 1'b0;
        checks++; if (bus.OUT_VALID !== 1'b0 || bus.FILL_COUNT !== 6'd1 || bus.OVERWRITE !== 1'b0) begin errors++; $display("FAIL b2b_diff: got valid %0b fill %0d ovw %0b exp 0 1 0", bus.OUT_VALID, bus.FILL_COUNT, bus.OVERWRITE); end
        tick();
        checks++; if (bus.OUT_ADDR !== 5'd9 || bus.OUT_DATA !== 32'd77) begin errors++; $display("FAIL b2b_load9: got addr %0d data %0d exp 9 77", bus.OUT_ADDR, bus.OUT_DATA); end
        bus.OUT_READY = 1'b1;
        wr_beat(5'd9, 32'd88);
        bus.OUT_READY = 1'b0;
        checks++; if (bus.OUT_VALID !== 1'b0 || bus.FILL_COUNT !== 6'd1 || bus.OVERWRITE !== 1'b0) begin errors++; $display("FAIL b2b_same: got valid %0b fill %0d ovw %0b exp 0 1 0", bus.OUT_VALID, bus.FILL_COUNT, bus.OVERWRITE); end
        tick();
        checks++; if (bus.OUT_VALID !== 1'b1 || bus.OUT_ADDR !== 5'd9 || bus.OUT_DATA !== 32'd88) begin errors++; $display("FAIL b2b_reload: got valid %0b addr %0d data %0d exp 1 9 88", bus.OUT_VALID, bus.OUT_ADDR, bus.OUT_DATA); end
        bus.OUT_READY = 1'b1;
        tick();
        checks++; if (bus.FILL_COUNT !== 6'd0) begin errors++; $display("FAIL b2b_empty: got fill %0d exp 0", bus.FILL_COUNT); end
        bus.OUT_READY = 1'b0;
    endtask

    task automatic test_dirty_hold();
        bus.OUT_READY = 1'b0;
        wr_beat(5'd1, 32'd10);
        tick();
        wr_beat(5'd1, 32'd55);
        checks++; if (bus.OUT_DATA !== 32'd10 || bus.OVERWRITE !== 1'b0 || bus.FILL_COUNT !== 6'd1) begin errors++; $display("FAIL dirty_snapshot: got data %0d ovw %0b fill %0d exp 10 0 1", bus.OUT_DATA, bus.OVERWRITE, bus.FILL_COUNT); end
        bus.OUT_READY = 1'b1;
        tick();
        checks++; if (bus.OUT_VALID !== 1'b0 || bus.FILL_COUNT !== 6'd1) begin errors++; $display("FAIL dirty_keep: got valid %0b fill %0d exp 0 1", bus.OUT_VALID, bus.FILL_COUNT); end
        tick();
        checks++; if (bus.OUT_VALID !== 1'b1 || bus.OUT_ADDR !== 5'd1 || bus.OUT_DATA !== 32'd55) begin errors++; $display("FAIL dirty_redrain: got valid %0b addr %0d data %0d exp 1 1 55", bus.OUT_VALID, bus.OUT_ADDR, bus.OUT_DATA); end
        tick();
        checks++; if (bus.FILL_COUNT !== 6'd0 || bus.OVERWRITE !== 1'b0) begin errors++; $display("FAIL dirty_done: got fill %0d ovw %0b exp 0 0", bus.FILL_COUNT, bus.OVERWRITE); end
        bus.OUT_READY = 1'b0;
    endtask

    task automatic test_overwrite();
        bus.OUT_READY = 1'b0;
        wr_beat(5'd2, 32'd2);
        wr_beat(5'd4, 32'd10);
        checks++; if (bus.OVERWRITE !== 1'b0) begin errors++; $display("FAIL ovw_early: got %0b exp 0", bus.OVERWRITE); end
        wr_beat(5'd4, 32'd11);
        checks++; if (bus.OVERWRITE !== 1'b1 || bus.OUT_ADDR !== 5'd2 || bus.FILL_COUNT !== 6'd2) begin errors++; $display("FAIL ovw_set: got ovw %0b addr %0d fill %0d exp 1 2 2", bus.OVERWRITE, bus.OUT_ADDR, bus.FILL_COUNT); end
        bus.OUT_READY = 1'b1;
        tick();
        checks++; if (bus.FILL_COUNT !== 6'd1) begin errors++; $display("FAIL ovw_pop2: got fill %0d exp 1", bus.FILL_COUNT); end
        tick();
        checks++; if (bus.OUT_ADDR !== 5'd4 || bus.OUT_DATA !== 32'd11) begin errors++; $display("FAIL ovw_drain4: got addr %0d data %0d exp 4 11", bus.OUT_ADDR, bus.OUT_DATA); end
        tick();
        checks++; if (bus.FILL_COUNT !== 6'd0 || bus.OVERWRITE !== 1'b1) begin errors++; $display("FAIL ovw_sticky: got fill %0d ovw %0b exp 0 1", bus.FILL_COUNT, bus.OVERWRITE); end
        bus.OUT_READY = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.OUT_READY = 1'b0;
        wr_beat(5'd1, 32'd1);
        wr_beat(5'd2, 32'd2);
        wr_beat(5'd3, 32'd3);
        checks++; if (bus.OUT_VALID !== 1'b1 || bus.FILL_COUNT !== 6'd3) begin errors++; $display("FAIL mid_pre: got valid %0b fill %0d exp 1 3", bus.OUT_VALID, bus.FILL_COUNT); end
        HRESET = 1'b1;
        wr_beat(5'd6, 32'd9);
        HRESET = 1'b0;
        checks++; if (bus.OUT_VALID !== 1'b0 || bus.FILL_COUNT !== 6'd0 || bus.OVERWRITE !== 1'b0) begin errors++; $display("FAIL mid_reset: got valid %0b fill %0d ovw %0b exp 0 0 0", bus.OUT_VALID, bus.FILL_COUNT, bus.OVERWRITE); end
        bus.OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.OUT_VALID !== 1'b0 || bus.FILL_COUNT !== 6'd0) begin errors++; $display("FAIL mid_quiet%0d: got valid %0b fill %0d exp 0 0", i, bus.OUT_VALID, bus.FILL_COUNT); end
        end
        bus.REG_ENABLE = 1'b1; bus.REG_WRITE = 1'b0; bus.RESPONSE_ADDR = 5'd6; bus.RESPONSE = 32'd42;
        tick();
        bus.REG_ENABLE = 1'b0; bus.REG_WRITE = 1'b1;
        tick();
        bus.REG_WRITE = 1'b0;
        tick();
        checks++; if (bus.OUT_VALID !== 1'b0 || bus.FILL_COUNT !== 6'd0) begin errors++; $display("FAIL no_store: got valid %0b fill %0d exp 0 0", bus.OUT_VALID, bus.FILL_COUNT); end
        bus.OUT_READY = 1'b0;
    endtask

    initial begin
        HRESET = 1'b1;
        test_reset();
        test_single_beat();
        test_ordering();
        test_backpressure();
        test_back_to_back();
        test_dirty_hold();
        test_overwrite();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
